console_history_printer: RTL and testbench
==========================================

# console_history_printer

Parametrised successor to the PS/2 command-line tracker. It keeps a scrolling history of committed keyboard lines plus one live edit line. On request it streams a window of every row to the character-display writer as indexed character beats. It sits between the PS/2 line assembler (upstream) and the screen character RAM writer (downstream), and adds history scrolling, a valid strobe and commit deferral during a sweep.

## Interface
Parameters:
- LINES, 8, total rows stored: rows 0..LINES-2 are history (0 = oldest), row LINES-1 is the live line.
- COLS, 32, characters per row. line_content is 8*COLS bits wide.
- PRINT_COLS, 12, leading columns of each row emitted per sweep (1..COLS).
- IDX_W, 8, char_index width. Must satisfy 2^IDX_W >= LINES*COLS.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request one print sweep. Sampled only in IDLE.
- line_content  in  8*COLS  live PS/2 line. Column 0 is bits [8*COLS-1 -: 8], MSB-first.
- line_commit  in  1  one-cycle pulse: push line_content into history.
- char_valid  out  1  char_index/char_data hold a beat this cycle.
- char_index  out  IDX_W  row*COLS + col.
- char_data  out  8  stored byte at (row, col).
- busy  out  1  sweep in progress (SCAN or DONE).
- finish  out  1  one-cycle pulse ending a sweep.
- commit_overflow  out  1  one-cycle pulse: a commit was dropped.

## Operation
- Live row LINES-1 is registered from line_content on every clock, regardless of state.
- Commit applied means:
  - row i <= row i+1 for i = 0..LINES-3;
  - row LINES-2 <= line_content;
  - row 0's old content is discarded.
- Commit in IDLE is applied at the same edge.
- Commit while busy sets a single pending flag. Row contents are not modified, so a sweep reads a stable history.
- Commit while pending is already set is dropped and pulses commit_overflow in the next cycle.
- State machine:
  - IDLE: start=1 -> SCAN with row=0, col=0.
  - SCAN: emit one beat per cycle. col increments to PRINT_COLS-1, then wraps to 0 and row increments. After beat (LINES-1, PRINT_COLS-1) -> DONE.
  - DONE: finish=1 for one cycle. The pending commit, if any, is applied at this edge and pending clears. -> IDLE.
- Commit arriving in the DONE cycle:
  - If pending is clear, it is applied at that edge.
  - If pending is set, the pending commit is applied and the new one is dropped with commit_overflow.
- start while busy is ignored; no queueing.
- start and line_commit in the same IDLE cycle: the commit is applied first, and the sweep sees the new history.
- The live row is read at the cycle its beats are emitted, so keystrokes during a sweep may appear.
- char_index = row*COLS + col, computed without truncation. Bits above IDX_W are zero by the parameter rule.

## Timing
- Reset values:
  - state IDLE, pending=0;
  - char_valid=0, char_index=0, char_data=8'h00;
  - busy=0, finish=0, commit_overflow=0;
  - all rows 8'h00.
- Reset mid-sweep: abort immediately, no finish pulse, pending commit discarded.
- All outputs are registered. With N = LINES*PRINT_COLS and start sampled at the end of cycle 0:
  - char_valid=1 in cycles 1..N;
  - finish=1 in cycle N+1, with char_valid=0;
  - busy=1 in cycles 1..N+1;
  - earliest next start is sampled in cycle N+2.
- Default N=96. Sweep-to-sweep period is N+2 = 98 cycles.
- Outside SCAN, char_valid=0 and char_index/char_data hold their last values.

## Test plan
- Reset, then start with line_content="HELLO" padded 8'h00:
  - 96 beats; beats for rows 0..6 carry data 8'h00;
  - row-7 beats have indices 224..235, data 'H','E','L','L','O',0...;
  - finish in cycle 97.
- Commit "LS", then "RUN", then start:
  - row 6 = "RUN", row 5 = "LS";
  - index 192 gives 'R', index 160 gives 'L'.
- Commit 8 distinct lines "L0".."L7", then sweep:
  - rows 0..6 = L1..L7 in order; oldest discarded.
- Commit in cycle 10 of a sweep:
  - all history beats show pre-commit data;
  - history shifts at the finish edge;
  - a second sweep shows the new line in row 6.
- Two commits during one sweep:
  - first is deferred, second is dropped;
  - commit_overflow pulses once.
- Reset asserted in cycle 40 of a sweep:
  - char_valid=0 next cycle, no finish pulse;
  - all rows cleared, pending cleared.
- start held high for 300 cycles:
  - back-to-back sweeps, each exactly 96 beats;
  - finish pulses 98 cycles apart.

Source files
------------

// File: rtl/console_history_printer.sv
// Scrolling keyboard-line history plus one live edit row, streamed to the
// character-display writer as indexed (row*COLS + col, byte) beats on request.
module console_history_printer #(
    parameter int LINES      = 8,
    parameter int COLS       = 32,
    parameter int PRINT_COLS = 12,
    parameter int IDX_W      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*COLS-1:0]    line_content,
    input  logic                 line_commit,
    output logic                 char_valid,
    output logic [IDX_W-1:0]     char_index,
    output logic [7:0]           char_data,
    output logic                 busy,
    output logic                 finish,
    output logic                 commit_overflow
);

    localparam int LW = 8 * COLS;
    localparam int RW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CW = (PRINT_COLS > 1) ? $clog2(PRINT_COLS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_reg;
    logic [LW-1:0]     row_view [LINES];
    logic [RW-1:0]     row_reg;
    logic [CW-1:0]     col_reg;
    logic              pending_reg;
    logic              last_reg;
    logic              char_valid_reg;
    logic [IDX_W-1:0]  char_index_reg;
    logic [7:0]        char_data_reg;
    logic              busy_reg;
    logic              finish_reg;
    logic              overflow_reg;

    logic              shift_now;
    logic              overflow_now;
    logic              last_pos;
    logic [LW-1:0]     first_row;
    logic [IDX_W-1:0]  index_next;

    function automatic logic [7:0] byte_at(input logic [LW-1:0] r, input logic [CW-1:0] c);
        return r[LW-1-8*int'(c) -: 8];
    endfunction

    always_comb begin
        shift_now    = ((state_reg == IDLE) && line_commit) ||
                       ((state_reg == DONE) && (pending_reg || line_commit));
        overflow_now = (state_reg != IDLE) && line_commit && pending_reg;
        // A commit coinciding with start shifts row 1 into row 0 at this very edge,
        // so the first beat must already see the post-commit row 0.
        first_row    = line_commit ? ((LINES > 2) ? row_view[1] : line_content) : row_view[0];
        last_pos     = (row_reg == RW'(LINES-1)) && (col_reg == CW'(PRINT_COLS-1));
        index_next   = IDX_W'(row_reg) * IDX_W'(COLS) + IDX_W'(col_reg);
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_row
            logic [LW-1:0] row_q;
            if (gi == LINES-1) begin : g_live
                always_ff @(posedge clock) begin
                    if (reset) row_q <= '0;
                    else       row_q <= line_content;
                end
            end else if (gi == LINES-2) begin : g_newest
                always_ff @(posedge clock) begin
                    if (reset)          row_q <= '0;
                    else if (shift_now) row_q <= line_content;
                end
            end else begin : g_older
                always_ff @(posedge clock) begin
                    if (reset)          row_q <= '0;
                    else if (shift_now) row_q <= row_view[gi+1];
                end
            end
            assign row_view[gi] = row_q;
        end
    endgenerate

    // row_reg/col_reg always point at the next beat to emit; last_reg marks that
    // the beat currently on the outputs is the final one of the sweep.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            pending_reg    <= 1'b0;
            last_reg       <= 1'b0;
            row_reg        <= '0;
            col_reg        <= '0;
            char_valid_reg <= 1'b0;
            char_index_reg <= '0;
            char_data_reg  <= 8'h00;
            busy_reg       <= 1'b0;
            finish_reg     <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            finish_reg   <= 1'b0;
            overflow_reg <= overflow_now;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg      <= SCAN;
                        busy_reg       <= 1'b1;
                        char_valid_reg <= 1'b1;
                        char_index_reg <= '0;
                        char_data_reg  <= byte_at(first_row, '0);
                        last_reg       <= (LINES * PRINT_COLS == 1);
                        if (PRINT_COLS == 1) begin
                            row_reg <= RW'(1);
                            col_reg <= '0;
                        end else begin
                            row_reg <= '0;
                            col_reg <= CW'(1);
                        end
                    end
                end
                SCAN: begin
                    if (line_commit && !pending_reg) pending_reg <= 1'b1;
                    if (last_reg) begin
                        state_reg      <= DONE;
                        char_valid_reg <= 1'b0;
                        finish_reg     <= 1'b1;
                    end else begin
                        char_index_reg <= index_next;
                        char_data_reg  <= byte_at(row_view[row_reg], col_reg);
                        last_reg       <= last_pos;
                        if (col_reg == CW'(PRINT_COLS-1)) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
                    pending_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign char_valid      = char_valid_reg;
    assign char_index      = char_index_reg;
    assign char_data       = char_data_reg;
    assign busy            = busy_reg;
    assign finish          = finish_reg;
    assign commit_overflow = overflow_reg;

endmodule

// File: tb/tb_console_history_printer.sv
// Directed bench for console_history_printer: sweeps, history scrolling,
// deferred/dropped commits, mid-sweep reset and back-to-back sweeps.
module tb_console_history_printer;

    localparam int LINES      = 8;
    localparam int COLS       = 32;
    localparam int PRINT_COLS = 12;
    localparam int IDX_W      = 8;
    localparam int LW         = 8 * COLS;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [LW-1:0]    line_content;
    logic             line_commit;
    logic             char_valid;
    logic [IDX_W-1:0] char_index;
    logic [7:0]       char_data;
    logic             busy;
    logic             finish;
    logic             commit_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap [256];
    int nbeats, fin_cyc, busy_cnt, ovf_cnt, seq_bad;

    console_history_printer #(
        .LINES(LINES), .COLS(COLS), .PRINT_COLS(PRINT_COLS), .IDX_W(IDX_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .line_content(line_content), .line_commit(line_commit),
        .char_valid(char_valid), .char_index(char_index), .char_data(char_data),
        .busy(busy), .finish(finish), .commit_overflow(commit_overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [LW-1:0] mkline(input string s);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < COLS; i++) v[LW-1-8*i -: 8] = s[i];
        return v;
    endfunction

    task automatic do_commit(input string s);
        line_content = mkline(s);
        line_commit  = 1'b1;
        @(negedge clock);
        line_commit  = 1'b0;
    endtask

    // Pulse start (optionally with a commit), then capture every beat until finish.
    task automatic run_sweep(input int c1, input int c2, input bit commit_start);
        int r, c;
        for (int i = 0; i < 256; i++) cap[i] = 8'hEE;
        nbeats = 0; fin_cyc = -1; busy_cnt = 0; ovf_cnt = 0; seq_bad = 0; r = 0; c = 0;
        start = 1'b1;
        line_commit = commit_start;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            line_commit = (cyc == c1) || (cyc == c2);
            if (char_valid) begin
                if (32'(char_index) !== 32'(r * COLS + c)) seq_bad++;
                cap[char_index] = char_data;
                nbeats++;
                if (c == PRINT_COLS - 1) begin c = 0; r++; end else c++;
            end
            if (busy) busy_cnt++;
            if (commit_overflow) ovf_cnt++;
            if (finish) begin fin_cyc = cyc; break; end
        end
        line_commit = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; line_commit = 1'b0; line_content = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_tests++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", char_valid); end
        n_tests++; if (char_index !== 8'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", char_index); end
        n_tests++; if (char_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", char_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b want 0", finish); end
        n_tests++; if (commit_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", commit_overflow); end
        $display("[TB] reset checked");
    endtask

    task automatic test_hello;
        string h;
        logic [7:0] exp_b;
        int nz;
        h = "HELLO";
        line_content = mkline(h);
        @(negedge clock);
        run_sweep(-1, -1, 1'b0);
        n_tests++; if (nbeats !== 96) begin n_fail++; $display("FAIL hello_beats: got %0d want 96", nbeats); end
        n_tests++; if (fin_cyc !== 97) begin n_fail++; $display("FAIL hello_finish_cycle: got %0d want 97", fin_cyc); end
        n_tests++; if (busy_cnt !== 97) begin n_fail++; $display("FAIL hello_busy_cycles: got %0d want 97", busy_cnt); end
        n_tests++; if (seq_bad !== 0) begin n_fail++; $display("FAIL hello_index_order: got %0d bad want 0", seq_bad); end
        nz = 0;
        for (int i = 0; i < 224; i++) if ((i % COLS) < PRINT_COLS && cap[i] !== 8'h00) nz++;
        n_tests++; if (nz !== 0) begin n_fail++; $display("FAIL hello_history_zero: got %0d nonzero want 0", nz); end
        for (int i = 0; i < PRINT_COLS; i++) begin
            exp_b = (i < 5) ? h[i] : 8'h00;
            n_tests++; if (cap[224+i] !== exp_b) begin n_fail++; $display("FAIL hello_live_col%0d: got %h want %h", i, cap[224+i], exp_b); end
        end
        n_tests++; if (char_valid !== 1'b0 || char_index !== 8'd235) begin n_fail++; $display("FAIL hello_hold: got valid=%b idx=%0d want 0/235", char_valid, char_index); end
        $display("[TB] hello sweep: %0d beats, finish in cycle %0d", nbeats, fin_cyc);
    endtask

    task automatic test_commit_order;
        do_commit("LS");
        do_commit("RUN");
        run_sweep(-1, -1, 1'b0);
        n_tests++; if (cap[192] !== "R") begin n_fail++; $display("FAIL order_192: got %h want 52", cap[192]); end
        n_tests++; if (cap[194] !== "N") begin n_fail++; $display("FAIL order_194: got %h want 4e", cap[194]); end
        n_tests++; if (cap[160] !== "L") begin n_fail++; $display("FAIL order_160: got %h want 4c", cap[160]); end
        n_tests++; if (cap[161] !== "S") begin n_fail++; $display("FAIL order_161: got %h want 53", cap[161]); end
        n_tests++; if (cap[128] !== 8'h00) begin n_fail++; $display("FAIL order_128: got %h want 00", cap[128]); end
        $display("[TB] commit order sweep done");
    endtask

    task automatic test_eight;
        for (int k = 0; k < 8; k++) do_commit($sformatf("L%0d", k));
        run_sweep(-1, -1, 1'b0);
        for (int r = 0; r < 7; r++) begin
            n_tests++; if (cap[r*32] !== "L") begin n_fail++; $display("FAIL eight_row%0d_c0: got %h want 4c", r, cap[r*32]); end
            n_tests++; if (cap[r*32+1] !== 8'(8'h31 + r)) begin n_fail++; $display("FAIL eight_row%0d_c1: got %h want %h", r, cap[r*32+1], 8'(8'h31 + r)); end
        end
        n_tests++; if (cap[225] !== "7") begin n_fail++; $display("FAIL eight_live: got %h want 37", cap[225]); end
        $display("[TB] eight commits sweep done");
    endtask

    task automatic test_deferred;
        line_content = mkline("NEW");
        @(negedge clock);
        run_sweep(10, -1, 1'b0);
        n_tests++; if (cap[193] !== "7") begin n_fail++; $display("FAIL defer_row6_pre: got %h want 37", cap[193]); end
        n_tests++; if (cap[1] !== "1") begin n_fail++; $display("FAIL defer_row0_pre: got %h want 31", cap[1]); end
        n_tests++; if (ovf_cnt !== 0) begin n_fail++; $display("FAIL defer_ovf: got %0d want 0", ovf_cnt); end
        run_sweep(-1, -1, 1'b0);
        n_tests++; if (cap[192] !== "N") begin n_fail++; $display("FAIL defer_row6_post: got %h want 4e", cap[192]); end
        n_tests++; if (cap[161] !== "7") begin n_fail++; $display("FAIL defer_row5_post: got %h want 37", cap[161]); end
        n_tests++; if (cap[1] !== "2") begin n_fail++; $display("FAIL defer_row0_post: got %h want 32", cap[1]); end
        $display("[TB] deferred commit sweeps done");
    endtask

    task automatic test_two_commits;
        line_content = mkline("X1");
        @(negedge clock);
        run_sweep(10, 20, 1'b0);
        n_tests++; if (ovf_cnt !== 1) begin n_fail++; $display("FAIL two_ovf: got %0d want 1", ovf_cnt); end
        n_tests++; if (cap[192] !== "N") begin n_fail++; $display("FAIL two_row6_pre: got %h want 4e", cap[192]); end
        run_sweep(-1, -1, 1'b0);
        n_tests++; if (cap[192] !== "X" || cap[193] !== "1") begin n_fail++; $display("FAIL two_row6_post: got %h%h want 5831", cap[192], cap[193]); end
        n_tests++; if (cap[160] !== "N") begin n_fail++; $display("FAIL two_row5_post: got %h want 4e", cap[160]); end
        n_tests++; if (cap[1] !== "3") begin n_fail++; $display("FAIL two_row0_post: got %h want 33", cap[1]); end
        n_tests++; if (ovf_cnt !== 0) begin n_fail++; $display("FAIL two_ovf_after: got %0d want 0", ovf_cnt); end
        $display("[TB] two commits sweep done");
    endtask

    task automatic test_start_commit;
        do_commit("A1"); do_commit("B2"); do_commit("C3");
        do_commit("D4"); do_commit("E5"); do_commit("F6");
        line_content = mkline("G7");
        run_sweep(-1, -1, 1'b1);
        n_tests++; if (cap[0] !== "A") begin n_fail++; $display("FAIL sc_row0_c0: got %h want 41", cap[0]); end
        n_tests++; if (cap[1] !== "1") begin n_fail++; $display("FAIL sc_row0_c1: got %h want 31", cap[1]); end
        n_tests++; if (cap[192] !== "G") begin n_fail++; $display("FAIL sc_row6: got %h want 47", cap[192]); end
        n_tests++; if (cap[160] !== "F") begin n_fail++; $display("FAIL sc_row5: got %h want 46", cap[160]); end
        n_tests++; if (fin_cyc !== 97) begin n_fail++; $display("FAIL sc_finish_cycle: got %0d want 97", fin_cyc); end
        $display("[TB] start with commit sweep done");
    endtask

    task automatic test_reset_mid;
        int cnt, nz;
        line_content = mkline("Z9");
        start = 1'b1;
        for (int cyc = 1; cyc <= 41; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            line_commit = (cyc == 10);
            reset = (cyc == 40);
        end
        n_tests++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", char_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (finish || char_valid) cnt++;
        end
        n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d active cycles want 0", cnt); end
        run_sweep(-1, -1, 1'b0);
        nz = 0;
        for (int i = 0; i < 224; i++) if ((i % COLS) < PRINT_COLS && cap[i] !== 8'h00) nz++;
        n_tests++; if (nz !== 0) begin n_fail++; $display("FAIL rmid_rows_cleared: got %0d nonzero want 0", nz); end
        n_tests++; if (cap[224] !== "Z") begin n_fail++; $display("FAIL rmid_live: got %h want 5a", cap[224]); end
        run_sweep(-1, -1, 1'b0);
        n_tests++; if (cap[192] !== 8'h00) begin n_fail++; $display("FAIL rmid_pending_cleared: got %h want 00", cap[192]); end
        $display("[TB] mid-sweep reset checked");
    endtask

    task automatic test_back_to_back;
        int nfin, beats, last_fin;
        nfin = 0; beats = 0; last_fin = -1;
        start = 1'b1;
        for (int cyc = 1; cyc <= 420; cyc++) begin
            @(negedge clock);
            start = (cyc < 300);
            if (char_valid) beats++;
            if (finish) begin
                nfin++;
                n_tests++; if (beats !== 96) begin n_fail++; $display("FAIL b2b_beats%0d: got %0d want 96", nfin, beats); end
                if (last_fin < 0) begin
                    n_tests++; if (cyc !== 97) begin n_fail++; $display("FAIL b2b_first_finish: got %0d want 97", cyc); end
                end else begin
                    n_tests++; if (cyc - last_fin !== 98) begin n_fail++; $display("FAIL b2b_period%0d: got %0d want 98", nfin, cyc - last_fin); end
                end
                $display("[TB] back-to-back finish %0d in cycle %0d, %0d beats", nfin, cyc, beats);
                last_fin = cyc;
                beats = 0;
            end
        end
        start = 1'b0;
        n_tests++; if (nfin !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", nfin); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; line_commit = 1'b0; line_content = '0;
        test_reset;
        test_hello;
        test_commit_order;
        test_eight;
        test_deferred;
        test_two_commits;
        test_start_commit;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
